pms_loader: RTL and testbench
=============================

# pms_loader

Boot-time program loader for the 16-bit processor's program management system. It accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit words. It writes each word into program memory through memory port 2 (the Memsrc/MemW2/a2_1/write2 path) and checks an XOR checksum. It holds the CPU off until a good image is resident, then releases it to fetch from BASE_ADDR.

## Interface
Parameters:
- BASE_ADDR, 16'h0000, memory word address of image word 0
- MAX_WORDS, 1024, largest accepted image length in words

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  byte on in_data is offered
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte this cycle
- rearm  in  1  single-cycle pulse; sampled only in DONE
- Memsrc  out  1  selects loader data onto memory port 2
- MemW2  out  1  memory port 2 write strobe
- a2_1  out  16  memory port 2 word address
- write2  out  16  memory port 2 write data
- busy  out  1  load in progress
- done  out  1  load finished (good or bad)
- err  out  1  checksum mismatch or oversize length
- cpu_hold  out  1  keep processor stalled (PC write inhibited)

## Operation
- Stream format: LEN_hi, LEN_lo, then N = {LEN_hi, LEN_lo} words as hi byte then lo byte, then one CHK byte.
- CHK must equal the XOR of all 2N data bytes. Length bytes are excluded. The XOR accumulator starts at 8'h00.
- States and transitions:
  - LEN_HI → LEN_LO: on accept.
  - LEN_LO → on accept:
    - DONE with err=1 if N > MAX_WORDS.
    - CHECK if N = 0.
    - DATA_HI otherwise.
  - DATA_HI → DATA_LO: on accept.
  - DATA_LO → WRITE: on accept.
  - WRITE (one cycle) → CHECK if k+1 = N, else DATA_HI. k increments.
  - CHECK → DONE: on accept. err = (byte != accumulator).
  - DONE → LEN_HI: on rearm. k, accumulator and err clear.
- A byte is accepted on a rising edge with in_valid && in_ready.
- in_ready = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; 0 in WRITE and DONE.
- WRITE cycle drives:
  - Memsrc = 1 and MemW2 = 1, for exactly that cycle.
  - a2_1 = BASE_ADDR + k, computed mod 2^16 so addresses wrap past 16'hFFFF.
  - write2 = {hi, lo}.
- a2_1 and write2 hold their last values outside WRITE.
- busy = 1 in every state except LEN_HI with no byte yet accepted, and except DONE.
- done = 1 only in DONE.
- cpu_hold = 0 only in DONE with err = 0.
- An oversize length produces no memory writes. Remaining stream bytes are not consumed until rearm. The loader then treats the next byte as LEN_HI.
- Bad checksum: the words already written stay in memory, and cpu_hold stays 1.
- rearm outside DONE is ignored.

## Timing
- Reset values: state LEN_HI, in_ready 1, Memsrc 0, MemW2 0, a2_1 16'h0000, write2 16'h0000, busy 0, done 0, err 0, cpu_hold 1, k 0, accumulator 0.
- Reset asserted mid-load aborts immediately. Any in-flight WRITE strobe drops asynchronously, and no partial word is written.
- All outputs are registered except in_ready, which is decoded from state.
- Latency from accepting a word's lo byte to its MemW2 pulse is 1 cycle.
- Minimum cost per word is 3 cycles (hi, lo, write).
- Latency from accepting CHK to done = 1 is 1 cycle.
- in_valid may drop at any time; a byte offered while in_ready = 0 is not consumed.

## Test plan
- Reset: hold rst_n low, then release → every output equals its reset value listed under Timing; in_ready = 1.
- Good load: stream 00 03 12 34 AB CD 00 01 41 → exactly three MemW2 pulses:
  - 16'h1234 @ 0
  - 16'hABCD @ 1
  - 16'h0001 @ 2

  Then done = 1, err = 0, cpu_hold = 0; reading the same addresses back through port 1 returns the same words.
- Bad checksum: same stream with CHK = 40 → same three writes, then done = 1, err = 1, cpu_hold = 1. A rearm pulse followed by a good stream then succeeds.
- Edge lengths:
  - Stream 00 00 00 → no MemW2, done = 1, err = 0.
  - Length 04 01 (1025 words) → done = 1, err = 1, no MemW2, in_ready = 0.
- Backpressure: insert random in_valid gaps and offer a byte during each WRITE cycle → that byte is not consumed (in_ready = 0). Writes, addresses and checksum are identical to the gap-free run.
- Mid-load reset: pulse rst_n low after the first word is written → all outputs return to reset values. A full reload with BASE_ADDR = 16'hFFFF and N = 2 then writes addresses FFFF and 0000.

Source files
------------

// File: rtl/pms_loader.sv
// pms_loader: boot-time program loader.
// Assembles big-endian words from a byte stream, writes them to program
// memory port 2 and verifies an XOR checksum before releasing the CPU.
//
// state     | meaning
// ----------+---------------------------------------------------------
// LEN_HI    | waiting for the high byte of the word count
// LEN_LO    | waiting for the low byte of the word count
// DATA_HI   | waiting for the high byte of word k
// DATA_LO   | waiting for the low byte of word k
// WRITE     | one-cycle memory write of word k, no byte accepted
// CHECK     | waiting for the checksum byte
// DONE      | load finished (good or bad), waiting for rearm
module pms_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        rearm,
  output logic        Memsrc,
  output logic        MemW2,
  output logic [15:0] a2_1,
  output logic [15:0] write2,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  localparam logic [2:0] S_LEN_HI  = 3'd0;
  localparam logic [2:0] S_LEN_LO  = 3'd1;
  localparam logic [2:0] S_DATA_HI = 3'd2;
  localparam logic [2:0] S_DATA_LO = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  // One extra bit so the length compare never truncates MAX_WORDS.
  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] k_q, k_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  hi_q, hi_d;
  logic        memsrc_q, memsrc_d;
  logic        memw2_q, memw2_d;
  logic [15:0] a2_1_q, a2_1_d;
  logic [15:0] write2_q, write2_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        accept;
  logic [15:0] len_new;

  // Byte acceptance is decoded straight from state so backpressure is immediate.
  always_comb begin
    in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
               (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
               (state_q == S_CHECK);
    accept   = in_valid && in_ready;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    k_d      = k_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    memsrc_d = 1'b0;
    memw2_d  = 1'b0;
    a2_1_d   = a2_1_q;
    write2_d = write2_q;
    err_d    = err_q;
    len_new  = {len_q[15:8], in_data};

    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {in_data, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = len_new;
          if ({1'b0, len_new} > MAX_W) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (len_new == 16'h0000) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = in_data;
          acc_d   = acc_q ^ in_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          acc_d    = acc_q ^ in_data;
          write2_d = {hi_q, in_data};
          a2_1_d   = BASE_ADDR + k_q;
          memsrc_d = 1'b1;
          memw2_d  = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        k_d     = k_q + 16'd1;
        state_d = ((k_q + 16'd1) == len_q) ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: begin
        if (accept) begin
          err_d   = (in_data != acc_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rearm) begin
          k_d     = 16'h0000;
          acc_d   = 8'h00;
          err_d   = 1'b0;
          state_d = S_LEN_HI;
        end
      end
      default: state_d = S_LEN_HI;
    endcase

    // LEN_HI is only ever occupied before its byte is taken, so it is never busy.
    busy_d     = !((state_d == S_LEN_HI) || (state_d == S_DONE));
    done_d     = (state_d == S_DONE);
    cpu_hold_d = !((state_d == S_DONE) && !err_d);
  end

  // State and output registers; reset aborts any load and drops the write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LEN_HI;
      len_q      <= 16'h0000;
      k_q        <= 16'h0000;
      acc_q      <= 8'h00;
      hi_q       <= 8'h00;
      memsrc_q   <= 1'b0;
      memw2_q    <= 1'b0;
      a2_1_q     <= 16'h0000;
      write2_q   <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      memsrc_q   <= memsrc_d;
      memw2_q    <= memw2_d;
      a2_1_q     <= a2_1_d;
      write2_q   <= write2_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  assign Memsrc   = memsrc_q;
  assign MemW2    = memw2_q;
  assign a2_1     = a2_1_q;
  assign write2   = write2_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_pms_loader.sv
// tb_pms_loader: randomized scoreboard bench for the program loader.
// Two instances: u0 loads at base 0, u1 at base FFFF for the wrap case.
module tb_pms_loader;

  localparam int MAXW = 1024;

  logic        clk, rst_n, in_valid, rearm, sel;
  logic [7:0]  in_data;
  logic        rdy0, src0, w0, busy0, done0, err0, hold0;
  logic        rdy1, src1, w1, busy1, done1, err1, hold1;
  logic [15:0] a0, d0, a1, d1;
  logic        v0, v1, r0, r1;

  assign v0 = in_valid & ~sel;
  assign v1 = in_valid & sel;
  assign r0 = rearm & ~sel;
  assign r1 = rearm & sel;

  pms_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(MAXW)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(in_data), .in_ready(rdy0),
    .rearm(r0), .Memsrc(src0), .MemW2(w0), .a2_1(a0), .write2(d0),
    .busy(busy0), .done(done0), .err(err0), .cpu_hold(hold0));

  pms_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(MAXW)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(in_data), .in_ready(rdy1),
    .rearm(r1), .Memsrc(src1), .MemW2(w1), .a2_1(a1), .write2(d1),
    .busy(busy1), .done(done1), .err(err1), .cpu_hold(hold1));

  logic rdy_s, busy_s, done_s, err_s, hold_s;
  assign rdy_s  = sel ? rdy1  : rdy0;
  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;
  assign err_s  = sel ? err1  : err0;
  assign hold_s = sel ? hold1 : hold0;

  int total = 0;
  int bad = 0;
  int writes_seen = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  stim[$];
  logic [15:0] mem [65536];
  logic        prev_w0 = 1'b0;
  logic        prev_w1 = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe pops one expected {addr, data} entry.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [15:0] ad, da;
    if (w0 || w1) begin
      writes_seen++;
      ad = w0 ? a0 : a1;
      da = w0 ? d0 : d1;
      chk("memsrc_with_w2", w0 ? src0 : src1, 1);
      chk("w2_single_cycle", w0 ? prev_w0 : prev_w1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", ad, e[31:16]);
        chk("wr_data", da, e[15:0]);
      end
      mem[ad] = da;
    end
    prev_w0 = w0;
    prev_w1 = w1;
  end

  task automatic chk_rst(input string tag, input logic r, s, w, b, dn, e, h,
                         input logic [15:0] a, d);
    chk({tag, "_flags"}, {r, s, w, b, dn, e, h}, 7'b1000001);
    chk({tag, "_a2_1"}, a, 16'h0000);
    chk({tag, "_write2"}, d, 16'h0000);
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    @(negedge clk);
    while (!rdy_s && t < 60) begin @(negedge clk); t++; end
    if (t >= 60) chk("send_timeout", t, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_rearm();
    rearm = 1'b1;
    @(posedge clk); #1;
    rearm = 1'b0;
    @(negedge clk);
    chk("rearm_done", done_s, 0);
    chk("rearm_ready", rdy_s, 1);
    chk("rearm_err", err_s, 0);
    chk("rearm_hold", hold_s, 1);
    @(posedge clk); #1;
  endtask

  // Reference model: derive writes, checksum result and byte count from stim.
  task automatic run_load(input int gapmax, input int rearm_idx);
    int n, nsend, exp_n, wb, t;
    logic [15:0] base;
    logic [7:0]  x;
    logic        exp_err;
    n    = int'({stim[0], stim[1]});
    base = sel ? 16'hFFFF : 16'h0000;
    wb   = writes_seen;
    if (n > MAXW) begin
      exp_err = 1'b1; nsend = 2; exp_n = 0;
    end else begin
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({base + 16'(i), stim[2+2*i], stim[3+2*i]});
        x ^= stim[2+2*i] ^ stim[3+2*i];
      end
      exp_err = (stim[2+2*n] != x);
      nsend = 2*n + 3;
      exp_n = n;
    end
    for (int i = 0; i < nsend; i++) begin
      if (i == rearm_idx) begin
        rearm = 1'b1; @(posedge clk); #1; rearm = 1'b0;
      end
      send_byte(stim[i], $urandom_range(0, gapmax));
    end
    t = 0;
    while (!done_s && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("done", done_s, 1);
    chk("err", err_s, exp_err);
    chk("cpu_hold", hold_s, exp_err);
    chk("ready_in_done", rdy_s, 0);
    chk("busy_in_done", busy_s, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("write_count", writes_seen - wb, exp_n);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic build_random(input int n, input bit good);
    logic [7:0] x, b;
    stim.delete();
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    x = 8'h00;
    for (int i = 0; i < 2*n; i++) begin
      b = 8'($urandom);
      stim.push_back(b);
      x ^= b;
    end
    stim.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
  endtask

  task automatic load_spec(input logic [7:0] c);
    stim = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, c};
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wb;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; rearm = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_rst("rst_u0", rdy0, src0, w0, busy0, done0, err0, hold0, a0, d0);
    chk_rst("rst_u1", rdy1, src1, w1, busy1, done1, err1, hold1, a1, d1);
    @(posedge clk); #1;

    // Good load; a rearm pulse mid-stream must be ignored.
    load_spec(8'h41);
    run_load(0, 3);
    chk("rd_0", mem[16'h0000], 16'h1234);
    chk("rd_1", mem[16'h0001], 16'hABCD);
    chk("rd_2", mem[16'h0002], 16'h0001);
    do_rearm();

    // Bad checksum, then recovery.
    load_spec(8'h40);
    run_load(0, -1);
    do_rearm();
    load_spec(8'h41);
    run_load(4, -1);
    do_rearm();

    // Zero length.
    stim = '{8'h00, 8'h00, 8'h00};
    run_load(1, -1);
    do_rearm();

    // Oversize length: nothing further consumed until rearm.
    stim = '{8'h04, 8'h01};
    run_load(0, -1);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) begin @(negedge clk); chk("oversize_ready", rdy0, 0); end
    @(posedge clk); #1 in_valid = 1'b0;
    do_rearm();

    // Largest accepted image.
    build_random(MAXW, 1'b1);
    run_load(0, -1);
    do_rearm();

    // Randomized loads with gaps and occasional bad checksums.
    for (int i = 0; i < 8; i++) begin
      build_random($urandom_range(0, 6), ($urandom_range(0, 2) != 0));
      run_load(3, -1);
      do_rearm();
    end

    // Mid-load reset during the second word's write cycle.
    build_random(3, 1'b1);
    exp_q.push_back({16'h0000, stim[2], stim[3]});
    wb = writes_seen;
    for (int i = 0; i < 6; i++) send_byte(stim[i], 0);
    chk("w2_before_rst", w0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_drops_w2", w0, 0);
    chk("rst_drops_src", src0, 0);
    chk("midload_writes", writes_seen - wb, 1);
    chk("midload_q", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_rst("midrst_u0", rdy0, src0, w0, busy0, done0, err0, hold0, a0, d0);
    @(posedge clk); #1;

    // Reload on the FFFF-based instance: addresses wrap.
    sel = 1'b1;
    stim = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_load(2, -1);
    chk("wrap_ffff", mem[16'hFFFF], 16'h1122);
    chk("wrap_0000", mem[16'h0000], 16'h3344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
